pipeline_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and PC.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 56 +++++
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl_sram_wait_counter.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, stall-source
// priority encoding and the per-stage control bundle.
package pipe_ctrl_pkg;

   localparam int unsigned REG_W_DEF = 4;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_e;

   // Higher value wins when several sources are active in the same cycle.
   typedef enum logic [1:0] {
      SRC_NONE   = 2'd0,
      SRC_HAZARD = 2'd1,
      SRC_BRANCH = 2'd2,
      SRC_MEM    = 2'd3
   } stall_src_e;

   typedef struct packed {
      logic pc_freeze;
      logic if_id_freeze;
      logic if_id_flush;
      logic id_ex_freeze;
      logic id_ex_flush;
      logic ex_mem_freeze;
      logic mem_wb_flush;
      logic mem_done;
   } ctrl_t;

   function automatic ctrl_t ctrl_for(input stall_src_e src);
      ctrl_t c;
      c = '0;
      case (src)
         SRC_MEM: begin
            c.pc_freeze     = 1'b1;
            c.if_id_freeze  = 1'b1;
            c.id_ex_freeze  = 1'b1;
            c.ex_mem_freeze = 1'b1;
            c.mem_wb_flush  = 1'b1;
         end
         SRC_BRANCH: begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
         end
         SRC_HAZARD: begin
            c.pc_freeze    = 1'b1;
            c.if_id_freeze = 1'b1;
            c.id_ex_flush  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in (master drives), per-stage
// freeze/flush and stall statistics out (slave = controller drives).
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned REG_W = 4,
   parameter int unsigned CNT_W = 16
);
   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic             id_src1_vld;
   logic             id_src2_vld;
   logic [REG_W-1:0] exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_read;
   logic [REG_W-1:0] mem_dest;
   logic             mem_wb_en;
   logic             mem_req;
   logic             branch_taken;

   logic             pc_freeze;
   logic             if_id_freeze;
   logic             if_id_flush;
   logic             id_ex_freeze;
   logic             id_ex_flush;
   logic             ex_mem_freeze;
   logic             mem_wb_flush;
   logic             mem_done;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_src1, id_src2, id_src1_vld, id_src2_vld,
             exe_dest, exe_wb_en, exe_mem_read,
             mem_dest, mem_wb_en, mem_req, branch_taken,
      input  pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze,
             id_ex_flush, ex_mem_freeze, mem_wb_flush, mem_done, stall_cycles
   );

   modport slave (
      input  id_src1, id_src2, id_src1_vld, id_src2_vld,
             exe_dest, exe_wb_en, exe_mem_read,
             mem_dest, mem_wb_en, mem_req, branch_taken,
      output pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze,
             id_ex_flush, ex_mem_freeze, mem_wb_flush, mem_done, stall_cycles
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_sram_wait_counter.sv
// Wait-state down-counter for multi-cycle SRAM accesses: load, decrement
// (stops at zero) and zero flag.
module sram_wait_counter #(
   parameter int unsigned CNT_W    = 3,
   parameter int unsigned LOAD_VAL = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_W'(LOAD_VAL);
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: SRAM wait-state FSM, branch flush and RAW stall
// priority mux plus saturating stall counter. `PIPE_FORWARDING_EN: load-use only.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W     = REG_W_DEF,
   parameter int unsigned SRAM_WAIT = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_hazard_ctrl_if.slave  bus
);
   localparam int unsigned WAIT_W   = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
   localparam int unsigned WAIT_LD  = (SRAM_WAIT > 0) ? SRAM_WAIT - 1 : 0;

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] stall_cycles_q;
   logic [CNT_W-1:0] stall_cycles_d;

   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero;
   logic       mem_stall;
   logic       mem_done_int;
   logic       exe_hit;
   logic       hazard;
   stall_src_e src;
   ctrl_t      ctrl;

   sram_wait_counter #(
      .CNT_W    (WAIT_W),
      .LOAD_VAL (WAIT_LD)
   ) u_wait_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .dec  (cnt_dec),
      .zero (cnt_zero)
   );

   assign exe_hit = bus.exe_wb_en &
                    ((bus.id_src1_vld & (bus.id_src1 == bus.exe_dest)) |
                     (bus.id_src2_vld & (bus.id_src2 == bus.exe_dest)));

`ifdef PIPE_FORWARDING_EN
   assign hazard = bus.exe_mem_read & exe_hit;
`else
   logic mem_hit;
   assign mem_hit = bus.mem_wb_en &
                    ((bus.id_src1_vld & (bus.id_src1 == bus.mem_dest)) |
                     (bus.id_src2_vld & (bus.id_src2 == bus.mem_dest)));
   assign hazard  = exe_hit | mem_hit;
`endif

   // The access cycle in RUN counts as the first stall, so WAIT loads SRAM_WAIT-1.
   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      mem_stall    = 1'b0;
      mem_done_int = 1'b0;
      if (SRAM_WAIT == 0) begin
         state_d      = RUN;
         mem_done_int = bus.mem_req;
      end else begin
         case (state_q)
            RUN: begin
               if (bus.mem_req) begin
                  mem_stall = 1'b1;
                  cnt_load  = 1'b1;
                  state_d   = WAIT;
               end
            end
            WAIT: begin
               if (!cnt_zero) begin
                  mem_stall = 1'b1;
                  cnt_dec   = 1'b1;
               end else begin
                  mem_done_int = 1'b1;
                  state_d      = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      src = SRC_NONE;
      if (mem_stall) begin
         src = SRC_MEM;
      end else if (bus.branch_taken) begin
         src = SRC_BRANCH;
      end else if (hazard) begin
         src = SRC_HAZARD;
      end
      ctrl          = ctrl_for(src);
      ctrl.mem_done = mem_done_int;
      if (rst) begin
         ctrl = '0;
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (ctrl.pc_freeze && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= RUN;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign bus.pc_freeze     = ctrl.pc_freeze;
   assign bus.if_id_freeze  = ctrl.if_id_freeze;
   assign bus.if_id_flush   = ctrl.if_id_flush;
   assign bus.id_ex_freeze  = ctrl.id_ex_freeze;
   assign bus.id_ex_flush   = ctrl.id_ex_flush;
   assign bus.ex_mem_freeze = ctrl.ex_mem_freeze;
   assign bus.mem_wb_flush  = ctrl.mem_wb_flush;
   assign bus.mem_done      = ctrl.mem_done;
   assign bus.stall_cycles  = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (SRAM_WAIT=4, CNT_W=4): per-cycle
// vector table with expected outputs pushed to a scoreboard and checked mid-cycle.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned REG_W = 4;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned SAT   = (1 << CNT_W) - 1;

   // Bit order: pc_fr, if_id_fr, if_id_fl, id_ex_fr, id_ex_fl, ex_mem_fr, mem_wb_fl, mem_done
   localparam logic [7:0] O_NONE = 8'b0000_0000;
   localparam logic [7:0] O_MEM  = 8'b1101_0110;
   localparam logic [7:0] O_DONE = 8'b0000_0001;
   localparam logic [7:0] O_BR   = 8'b0010_1000;
   localparam logic [7:0] O_HAZ  = 8'b1100_1000;
`ifdef PIPE_FORWARDING_EN
   localparam logic [7:0] O_HX   = O_NONE;
`else
   localparam logic [7:0] O_HX   = O_HAZ;
`endif

   typedef struct {
      logic             rst;
      logic [REG_W-1:0] s1;
      logic             v1;
      logic [REG_W-1:0] s2;
      logic             v2;
      logic [REG_W-1:0] ed;
      logic             ewb;
      logic             erd;
      logic [REG_W-1:0] md;
      logic             mwb;
      logic             mreq;
      logic             br;
      logic [7:0]       exp;
      string            name;
   } vec_t;

   typedef struct {
      logic [7:0]       o;
      logic [CNT_W-1:0] sc;
      string            name;
      int               idx;
   } exp_t;

   logic clk;
   logic rst;
   pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

   pipeline_hazard_ctrl #(
      .REG_W     (REG_W),
      .SRAM_WAIT (4),
      .CNT_W     (CNT_W)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   sc_model = 0;

   function automatic vec_t mk(input logic r, input int s1, input logic v1,
                               input int s2, input logic v2, input int ed,
                               input logic ewb, input logic erd, input int md,
                               input logic mwb, input logic mreq, input logic br,
                               input logic [7:0] exp, input string name);
      vec_t v;
      v.rst = r;  v.s1 = REG_W'(s1); v.v1 = v1; v.s2 = REG_W'(s2); v.v2 = v2;
      v.ed = REG_W'(ed); v.ewb = ewb; v.erd = erd; v.md = REG_W'(md);
      v.mwb = mwb; v.mreq = mreq; v.br = br; v.exp = exp; v.name = name;
      return v;
   endfunction

   task automatic check_out();
      exp_t       e;
      logic [7:0] got;
      if (sb.size() == 0) begin
         checks++;
         $display("FAIL sb_empty: got no expectation, required one");
         return;
      end
      e   = sb.pop_front();
      got = {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush, bus.id_ex_freeze,
             bus.id_ex_flush, bus.ex_mem_freeze, bus.mem_wb_flush, bus.mem_done};
      checks++;
      if (got === e.o) passed++;
      else $display("FAIL %s[%0d] ctrl: actual %b required %b", e.name, e.idx, got, e.o);
      checks++;
      if (bus.stall_cycles === e.sc) passed++;
      else $display("FAIL %s[%0d] stall_cycles: actual %0d required %0d",
                    e.name, e.idx, bus.stall_cycles, e.sc);
   endtask

   task automatic run_row(input vec_t v, input int idx);
      exp_t e;
      @(posedge clk);
      #1;
      rst              = v.rst;
      bus.id_src1      = v.s1;   bus.id_src1_vld = v.v1;
      bus.id_src2      = v.s2;   bus.id_src2_vld = v.v2;
      bus.exe_dest     = v.ed;   bus.exe_wb_en   = v.ewb;
      bus.exe_mem_read = v.erd;
      bus.mem_dest     = v.md;   bus.mem_wb_en   = v.mwb;
      bus.mem_req      = v.mreq; bus.branch_taken = v.br;
      if (v.rst) sc_model = 0;
      e.o = v.exp; e.sc = CNT_W'(sc_model); e.name = v.name; e.idx = idx;
      sb.push_back(e);
      @(negedge clk);
      check_out();
      if (!v.rst && v.exp[7] && (sc_model < int'(SAT))) sc_model++;
   endtask

   initial begin
      rst = 1'b1;
      bus.id_src1 = '0; bus.id_src1_vld = 1'b0; bus.id_src2 = '0; bus.id_src2_vld = 1'b0;
      bus.exe_dest = '0; bus.exe_wb_en = 1'b0; bus.exe_mem_read = 1'b0;
      bus.mem_dest = '0; bus.mem_wb_en = 1'b0; bus.mem_req = 1'b0; bus.branch_taken = 1'b0;

      //          rst s1 v1 s2 v2 ed ewb erd md mwb mreq br  exp
      vecs.push_back(mk(1, 3, 1, 0, 0, 3, 1, 1, 0, 0, 1, 1, O_NONE, "reset_forces_0"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "idle"));
      vecs.push_back(mk(0, 1, 1, 2, 1, 4, 1, 0, 5, 1, 0, 0, O_NONE, "no_match"));
      vecs.push_back(mk(0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, O_HX,   "raw_exe"));
      vecs.push_back(mk(0, 0, 0, 6, 1, 1, 0, 0, 6, 1, 0, 0, O_HX,   "raw_mem_src2"));
      vecs.push_back(mk(0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, O_NONE, "src_not_read"));
      vecs.push_back(mk(0, 7, 1, 0, 0, 7, 0, 0, 7, 0, 0, 0, O_NONE, "dest_no_wb"));
      vecs.push_back(mk(0, 3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, O_HAZ,  "load_use_1"));
      vecs.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, O_HX,   "load_use_2"));
      vecs.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "load_use_3"));
      vecs.push_back(mk(0, 3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 1, O_BR,   "branch_over_hazard"));
      vecs.push_back(mk(0, 3, 1, 0, 0, 3, 1, 1, 0, 0, 1, 0, O_MEM,  "mem_over_hazard"));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_MEM, "wait_ignores_branch"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_BR | O_DONE, "done_with_branch"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BR,   "branch_after_wait"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "idle_after_mem"));

      // Reset mid-WAIT with the counter at 2, then a full access must stall 4 again.
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MEM, "pre_abort"));
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE, "rst_mid_wait"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "post_rst_idle"));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MEM, "reissue_stall"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_DONE, "reissue_done"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "reissue_idle"));

      // Saturation: 20 hazard cycles from a cleared counter end at all-ones and hold.
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "sat_reset"));
      for (int i = 0; i < 20; i++)
         vecs.push_back(mk(0, 2, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, O_HAZ, "sat_hazard"));
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, "sat_hold"));

      foreach (vecs[i]) run_row(vecs[i], i);

      if (sb.size() != 0) begin
         checks++;
         $display("FAIL sb_leftover: actual %0d entries required 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
